// File: rtl/uart_rx_frame.sv
// Asynchronous serial receiver: start + DATA_BITS (LSB first) [+ parity] + stop, programmable bit period.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16:0]          bit_period,
    input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic [16:0]            tmr_q;
    logic [16:0]            per_q;
    logic [16:0]            per_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [3:0]             cnt_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   rxd_s;
    logic                   tick;
`ifdef UART_RX_PARITY_EN
    logic                   perr_q;
    logic                   par_bad_q;
`endif

    assign rxd_s = sync_q[1];
    assign tick  = (tmr_q == 17'd0);
    assign per_d = (bit_period < 17'd4) ? 17'd4 : bit_period;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT_HIGH;
            sync_q    <= 2'b11;
            tmr_q     <= '0;
            per_q     <= 17'd4;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rxd};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            // Free-running bit timer; reloads a full period on every sample.
            if (tick) tmr_q <= per_q - 17'd1;
            else      tmr_q <= tmr_q - 17'd1;

            case (state_q)
                S_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!rxd_s) begin
                        per_q   <= per_d;
                        tmr_q   <= (per_d >> 1) - 17'd1;
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_bad_q <= rxd_s != ((^shift_q) ^ parity_odd);
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (rxd_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= par_bad_q;
`endif
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Low stop bit: wait for the line to recover, which also rides out a break.
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state_q <= S_WAIT_HIGH;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed scenarios plus randomized frames, checked against
// event times and values computed arithmetically from the frame layout.
module tb_uart_rx_frame;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [16:0]   bit_period = 17'd16;
    logic [DB-1:0] data_out;
    logic          valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    uart_rx_frame #(.DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_period (bit_period),
        .rxd        (rxd),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = valid (with data), 1 = frame_err, 2 = parity_err
    typedef struct {
        int            t;
        int            kind;
        logic [DB-1:0] d;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];
    int  vectors = 0;
    int  errs    = 0;

    always @(negedge clk) begin
        if (valid)     act_q.push_back('{t: cyc, kind: 0, d: data_out});
        if (frame_err) act_q.push_back('{t: cyc, kind: 1, d: '0});
`ifdef UART_RX_PARITY_EN
        if (parity_err) act_q.push_back('{t: cyc, kind: 2, d: '0});
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, ".count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk({tag, ".edge"}, 64'(act_q[i].t),    64'(exp_q[i].t));
            chk({tag, ".kind"}, 64'(act_q[i].kind), 64'(exp_q[i].kind));
            chk({tag, ".data"}, 64'(act_q[i].d),    64'(exp_q[i].d));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the next posedge is edge 0 of the frame.
    task automatic send_frame(input logic [DB-1:0] d, input int praw, input bit stop_ok,
                              input bit pbit, input bit scramble);
        int p, t0, ts;
        p  = (praw < 4) ? 4 : praw;
        t0 = cyc + 1;
        ts = t0 + 2 + p / 2 + (DB + 1 + PB) * p;
        if (stop_ok) begin
            exp_q.push_back('{t: ts, kind: 0, d: d});
`ifdef UART_RX_PARITY_EN
            if (pbit != ((^d) ^ parity_odd)) exp_q.push_back('{t: ts, kind: 2, d: '0});
`endif
        end else begin
            exp_q.push_back('{t: ts, kind: 1, d: '0});
        end
        bit_period = praw[16:0];
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        if (scramble) bit_period = 17'($urandom_range(0, 17'h1ffff));
        repeat (p - 3) @(negedge clk);
        for (int k = 0; k < DB; k++) drive_bit(d[k], p);
        if (PB != 0) drive_bit(pbit, p);
        drive_bit(stop_ok, p);
    endtask

    initial begin
        int pr, gap;
        bit sok;
        logic [DB-1:0] rd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.data_out",  64'(data_out),  64'h0);
        chk("reset.valid",     64'(valid),     64'h0);
        chk("reset.frame_err", 64'(frame_err), 64'h0);
        chk("reset.busy",      64'(busy),      64'h1);
        rst = 1'b0;
        idle(4);
        chk("idle.busy", 64'(busy), 64'h0);

        // Nominal 0xA5 at P=16: valid at edge 154 of the frame
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0);
        idle(5);
        if (exp_q.size() > 0) chk("a5.latency", 64'(exp_q[0].t - (cyc - 5 - 159)), 64'd154);
        drain("a5");
        chk("a5.busy_after", 64'(busy), 64'h0);

        // Quarter-bit glitch is rejected at the start sample
        drive_bit(1'b0, 4);
        idle(30);
        drain("glitch");
        chk("glitch.busy", 64'(busy), 64'h0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0);
        idle(5);
        drain("3c");

        // Low stop bit followed by a 40-cycle break
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 40);
        chk("brk.busy_low",  64'(busy),     64'h1);
        chk("brk.data_hold", 64'(data_out), 64'h3C);
        drain("brk");
        idle(6);
        chk("brk.busy_recover", 64'(busy), 64'h0);
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b0);
        idle(5);
        drain("81");

        // Back-to-back frames with zero idle gap at P=5
        send_frame(8'h00, 5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b0);
        idle(10);
        if (act_q.size() >= 2) chk("b2b.spacing", 64'(act_q[1].t - act_q[0].t), 64'd50);
        drain("b2b");

        // Reset at edge 60 of a 0xA5 frame aborts it
        fork
            send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        exp_q.delete();
        drain("abort");
        chk("abort.data_out", 64'(data_out), 64'h0);
        // The tail of the aborted frame can look like a fresh start once the
        // synchronizer leaves reset high; let it play out before the next frame.
        idle(120);
        act_q.delete();
        send_frame(8'h12, 16, 1'b1, 1'b0, 1'b0);
        idle(5);
        drain("12");

`ifdef UART_RX_PARITY_EN
        // Even parity, wrong parity bit: valid and parity_err together at edge 170
        parity_odd = 1'b0;
        send_frame(8'h07, 16, 1'b1, 1'b0, 1'b0);
        idle(5);
        drain("par07");
`endif

        // Randomized frames: clamped periods, bad stops, gaps, mid-frame period changes
        for (int i = 0; i < 30; i++) begin
            rd  = DB'($urandom);
            pr  = $urandom_range(0, 20);
            sok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            parity_odd = 1'($urandom);
`endif
            send_frame(rd, pr, sok, 1'($urandom), 1'b1);
            gap = sok ? $urandom_range(0, 6) : $urandom_range(2, 8);
            idle(gap);
        end
        idle(12);
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
